// File: rtl/dm_hart_run_ctrl.sv
// dm_hart_run_ctrl
//   Per-hart run-control sequencer for the debug module. Turns the DMCONTROL
//   haltreq level and resumereq pulse into a debug request line and a
//   "go/resume" flag per hart, follows the HALTED/RESUMING flag write-backs
//   from the debug ROM, keeps a sticky resumeack per hart and registers the
//   debug-mode exception pulse.
//
// Ports
//   clk_i           clock (single domain)
//   rst_ni          asynchronous active-low reset
//   hartsel_i       hart selected by DMCONTROL.hartsel
//   haltreq_i       halt request level for the selected hart
//   resumereq_i     one-cycle resume request pulse for the selected hart
//   halted_i        per-hart pulse: hart entered debug mode
//   resuming_i      per-hart pulse: hart is leaving debug mode
//   exception_i     pulse: hart trapped while in debug mode
//   debug_req_o     per-hart debug request (state HALT_PEND)
//   resume_o        per-hart resume flag polled by the ROM (state RESUME_PEND)
//   halted_o        per-hart halted status (HALTED or RESUME_PEND)
//   sel_halted_o    selected hart is halted
//   sel_running_o   selected hart is running (RUNNING or HALT_PEND)
//   sel_resumeack_o selected hart sticky resumeack
//   sel_nonexist_o  hartsel_i addresses a hart that does not exist
//   exc_o           registered exception_i pulse
module dm_hart_run_ctrl #(
    parameter int unsigned NrHarts  = 1,
    parameter int unsigned HartSelW = (NrHarts == 1) ? 1 : $clog2(NrHarts)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [HartSelW-1:0] hartsel_i,
    input  logic                haltreq_i,
    input  logic                resumereq_i,
    input  logic [NrHarts-1:0]  halted_i,
    input  logic [NrHarts-1:0]  resuming_i,
    input  logic                exception_i,
    output logic [NrHarts-1:0]  debug_req_o,
    output logic [NrHarts-1:0]  resume_o,
    output logic [NrHarts-1:0]  halted_o,
    output logic                sel_halted_o,
    output logic                sel_running_o,
    output logic                sel_resumeack_o,
    output logic                sel_nonexist_o,
    output logic                exc_o
);

    typedef enum logic [1:0] {
        ST_RUNNING     = 2'd0,
        ST_HALT_PEND   = 2'd1,
        ST_HALTED      = 2'd2,
        ST_RESUME_PEND = 2'd3
    } state_e;

    state_e             state_r [NrHarts];
    state_e             state_s [NrHarts];
    logic [NrHarts-1:0] resumeack_r;
    logic [NrHarts-1:0] resumeack_s;
    logic [NrHarts-1:0] sel_s;
    logic [NrHarts-1:0] running_s;
    logic               nonexist_s;
    logic               exc_r;

    // The select index is widened so out-of-range values compare correctly
    // even when NrHarts is not a power of two.
    assign nonexist_s = (32'(hartsel_i) >= NrHarts);

    // One-hot decode of the selected hart; nothing is selected when hartsel is out of range.
    always_comb begin
        for (int unsigned h = 0; h < NrHarts; h++) begin
            sel_s[h] = (32'(hartsel_i) == h) && !nonexist_s;
        end
    end

    // Next-state and resumeack update for every hart.
    always_comb begin
        for (int unsigned h = 0; h < NrHarts; h++) begin
            state_s[h]     = state_r[h];
            resumeack_s[h] = resumeack_r[h];
            case (state_r[h])
                ST_RUNNING: begin
                    // Self-halt (ebreak, step, trigger) is honoured regardless of selection.
                    if (halted_i[h]) begin
                        state_s[h] = ST_HALTED;
                    end else if (sel_s[h] && haltreq_i) begin
                        state_s[h] = ST_HALT_PEND;
                    end else begin
                        state_s[h] = ST_RUNNING;
                    end
                end
                ST_HALT_PEND: begin
                    // The hart's acknowledgement wins over a request withdrawn in the same cycle.
                    if (halted_i[h]) begin
                        state_s[h] = ST_HALTED;
                    end else if (!(sel_s[h] && haltreq_i)) begin
                        state_s[h] = ST_RUNNING;
                    end else begin
                        state_s[h] = ST_HALT_PEND;
                    end
                end
                ST_HALTED: begin
                    // A resume is only accepted while no halt is being requested.
                    if (sel_s[h] && resumereq_i && !haltreq_i) begin
                        state_s[h]     = ST_RESUME_PEND;
                        resumeack_s[h] = 1'b0;
                    end else begin
                        state_s[h] = ST_HALTED;
                    end
                end
                ST_RESUME_PEND: begin
                    if (resuming_i[h]) begin
                        state_s[h]     = ST_RUNNING;
                        resumeack_s[h] = 1'b1;
                    end else begin
                        state_s[h] = ST_RESUME_PEND;
                    end
                end
                default: begin
                    state_s[h] = ST_RUNNING;
                end
            endcase
        end
    end

    // Per-hart state and sticky resumeack registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned h = 0; h < NrHarts; h++) begin
                state_r[h] <= ST_RUNNING;
            end
            resumeack_r <= '0;
        end else begin
            for (int unsigned h = 0; h < NrHarts; h++) begin
                state_r[h] <= state_s[h];
            end
            resumeack_r <= resumeack_s;
        end
    end

    // Exception pulse delayed by one cycle; run state is not affected.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exc_r <= 1'b0;
        end else begin
            exc_r <= exception_i;
        end
    end

    // Per-hart outputs decoded purely from the state registers.
    always_comb begin
        for (int unsigned h = 0; h < NrHarts; h++) begin
            debug_req_o[h] = (state_r[h] == ST_HALT_PEND);
            resume_o[h]    = (state_r[h] == ST_RESUME_PEND);
            halted_o[h]    = (state_r[h] == ST_HALTED) || (state_r[h] == ST_RESUME_PEND);
            running_s[h]   = (state_r[h] == ST_RUNNING) || (state_r[h] == ST_HALT_PEND);
        end
    end

    // Selected-hart status: sel_s is all-zero for a nonexistent hart, so these read 0 then.
    assign sel_halted_o    = |(halted_o & sel_s);
    assign sel_running_o   = |(running_s & sel_s);
    assign sel_resumeack_o = |(resumeack_r & sel_s);
    assign sel_nonexist_o  = nonexist_s;
    assign exc_o           = exc_r;

endmodule
